// File: rtl/write_queue_pkg.sv
// Shared definitions for the write queue: FSM state encoding and request layout.
package write_queue_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'b00;
    localparam state_t REQ  = 2'b01;
    localparam state_t HOLD = 2'b10;
    localparam state_t REL  = 2'b11;

    localparam int unsigned DEF_AW = 4;
    localparam int unsigned DEF_DW = 8;

    // Default-width request record; the top re-declares it with its own AW/DW.
    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] data;
    } req_t;

endpackage

// File: rtl/req_fifo.sv
// Circular synchronous FIFO with registered full/empty/count and a head-of-queue output.
module req_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/write_queue.sv
// Buffers write requests and issues them one at a time over the wrt/busy/en_n handshake,
// holding address and data stable for the whole slow-clock write.
module write_queue
    import write_queue_pkg::*;
#(
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [AW-1:0]                push_addr,
    input  logic [DW-1:0]                push_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         wrt,
    input  logic                         busy,
    input  logic                         en_n,
    output logic [AW-1:0]                addr_out,
    output logic [DW-1:0]                data_out,
    output logic                         done
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wq_req_t;

    state_t  state;
    wq_req_t push_req;
    wq_req_t head_req;
    logic    pop;

    assign push_req = {push_addr, push_data};

    // The head entry is only released once the device has fully finished with it.
    assign pop = (state == REL) && !busy;

    req_fifo #(
        .WIDTH ($bits(wq_req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .head      (head_req),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_out <= '0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty && !busy) begin
                        state    <= REQ;
                        addr_out <= head_req.addr;
                        data_out <= head_req.data;
                    end
                end
                REQ:  if (!en_n) state <= HOLD;
                HOLD: if (en_n)  state <= REL;
                REL: begin
                    if (!busy) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wrt = (state == REQ) || (state == HOLD);

endmodule

// File: tb/tb_write_queue.sv
// Directed bench for write_queue with a behavioural write_synch model on an 8-cycle slow clock.
module tb_write_queue;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic [AW-1:0] push_addr;
    logic [DW-1:0] push_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          wrt;
    logic          busy;
    logic          en_n = 1'b1;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] data_out;
    logic          done;

    write_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (push_addr),
        .push_data (push_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .wrt       (wrt),
        .busy      (busy),
        .en_n      (en_n),
        .addr_out  (addr_out),
        .data_out  (data_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    // write_synch model: busy one cycle after wrt, en_n low for 4 cycles from the next slc rise,
    // busy released once wrt has dropped. It has no reset, like the real block.
    logic       m_busy    = 1'b0;
    logic       busy_hold = 1'b0;
    logic [1:0] ms        = 2'd0;
    logic [2:0] slc_cnt   = 3'd0;
    logic [2:0] en_cnt    = 3'd0;

    assign busy = m_busy | busy_hold;

    always @(posedge clk) begin
        slc_cnt <= slc_cnt + 3'd1;
        case (ms)
            2'd0: if (wrt === 1'b1) begin m_busy <= 1'b1; ms <= 2'd1; end
            2'd1: if (slc_cnt == 3'd7) begin en_n <= 1'b0; en_cnt <= 3'd0; ms <= 2'd2; end
            2'd2: begin
                en_cnt <= en_cnt + 3'd1;
                if (en_cnt == 3'd3) begin en_n <= 1'b1; ms <= 2'd3; end
            end
            default: if (wrt === 1'b0) begin m_busy <= 1'b0; ms <= 2'd0; end
        endcase
    end

    // Device-side observer
    logic [AW+DW-1:0] seen [$];
    logic [AW+DW-1:0] cur = '0;
    logic             prev_en_n = 1'b1;
    int               en_len = 0;
    int               last_en_len = 0;
    int               stab_err = 0;
    int               done_cnt = 0;

    always @(negedge clk) begin
        if (en_n === 1'b0) begin
            if (prev_en_n) begin
                cur = {addr_out, data_out};
                seen.push_back(cur);
                en_len = 0;
            end
            en_len++;
            if ({addr_out, data_out} !== cur) stab_err++;
        end else if (!prev_en_n) begin
            last_en_len = en_len;
        end
        prev_en_n = en_n;
        if (done === 1'b1) done_cnt++;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < 80);
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(empty === 1'b1 && wrt === 1'b0 && busy === 1'b0 && en_n === 1'b1) && n < 200) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(n < 200), 32'd1);
        tick();
    endtask

    typedef struct {
        logic          push;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [CW-1:0] exp_count;
        logic          exp_full;
        logic          exp_empty;
    } vec_t;

    vec_t vt [5];

    initial begin
        int n;
        int early;
        int dc;
        logic [AW+DW-1:0] e;

        vt[0] = '{1'b1, 4'h1, 8'h11, 3'd1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 4'h2, 8'h22, 3'd2, 1'b0, 1'b0};
        vt[2] = '{1'b1, 4'h3, 8'h33, 3'd3, 1'b0, 1'b0};
        vt[3] = '{1'b1, 4'h4, 8'h44, 3'd4, 1'b1, 1'b0};
        vt[4] = '{1'b1, 4'h5, 8'h55, 3'd4, 1'b1, 1'b0};

        rst = 1'b1; push = 1'b0; push_addr = '0; push_data = '0;
        repeat (3) tick();
        check("rst_wrt",   32'(wrt),      32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_addr",  32'(addr_out), 32'd0);
        check("rst_data",  32'(data_out), 32'd0);
        check("rst_count", 32'(count),    32'd0);
        check("rst_empty", 32'(empty),    32'd1);
        check("rst_full",  32'(full),     32'd0);
        rst = 1'b0;
        tick();

        // 1: single write, latency and pulse shape
        push = 1'b1; push_addr = 4'h3; push_data = 8'hA5;
        tick();
        push = 1'b0;
        check("t1_wrt_edge1", 32'(wrt),   32'd0);
        check("t1_count1",    32'(count), 32'd1);
        tick();
        check("t1_wrt_edge2", 32'(wrt),      32'd1);
        check("t1_addr",      32'(addr_out), 32'h3);
        check("t1_data",      32'(data_out), 32'hA5);
        wait_done("t1_done");
        check("t1_count_at_done", 32'(count), 32'd0);
        wait_idle();
        check("t1_done_cnt", 32'(done_cnt),    32'd1);
        check("t1_writes",   32'(seen.size()), 32'd1);
        if (seen.size() >= 1) check("t1_seen", 32'(seen[0]), 32'h3A5);
        check("t1_en_len",   32'(last_en_len), 32'd4);
        check("t1_stable",   32'(stab_err),    32'd0);

        // 2: fill to full, overflow push dropped
        seen.delete();
        foreach (vt[i]) begin
            push = vt[i].push; push_addr = vt[i].addr; push_data = vt[i].data;
            tick();
            check($sformatf("t2_count_%0d", i), 32'(count), 32'(vt[i].exp_count));
            check($sformatf("t2_full_%0d", i),  32'(full),  32'(vt[i].exp_full));
            check($sformatf("t2_empty_%0d", i), 32'(empty), 32'(vt[i].exp_empty));
        end
        push = 1'b0;
        for (int k = 0; k < 4; k++) wait_done($sformatf("t2_done_%0d", k));
        wait_idle();
        check("t2_writes", 32'(seen.size()), 32'd4);
        for (int k = 0; k < 4 && k < seen.size(); k++)
            check($sformatf("t2_seen_%0d", k), 32'(seen[k]), 32'({vt[k].addr, vt[k].data}));

        // 3: push on the same edge as a pop with count=2
        seen.delete();
        push = 1'b1; push_addr = 4'h1; push_data = 8'h61;
        tick();
        push_addr = 4'h2; push_data = 8'h62;
        tick();
        push = 1'b0;
        n = 0;
        while (!(seen.size() >= 1 && en_n === 1'b1 && busy === 1'b0) && n < 100) begin
            tick();
            n++;
        end
        check("t3_reach_pop", 32'(n < 100), 32'd1);
        check("t3_count_pre", 32'(count),   32'd2);
        push = 1'b1; push_addr = 4'h3; push_data = 8'h63;
        tick();
        push = 1'b0;
        check("t3_count_post", 32'(count), 32'd2);
        check("t3_done",       32'(done),  32'd1);
        wait_done("t3_done_2");
        wait_done("t3_done_3");
        wait_idle();
        check("t3_writes", 32'(seen.size()), 32'd3);
        for (int k = 0; k < 3 && k < seen.size(); k++)
            check($sformatf("t3_seen_%0d", k), 32'(seen[k]), 32'({4'(k + 1), 8'(8'h61 + k)}));

        // 4: reset during HOLD
        seen.delete();
        push = 1'b1; push_addr = 4'h7; push_data = 8'h77;
        tick();
        push = 1'b0;
        n = 0;
        while (en_n !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        tick();
        check("t4_in_hold", 32'(wrt), 32'd1);
        dc = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_rst_wrt",   32'(wrt),   32'd0);
        check("t4_rst_empty", 32'(empty), 32'd1);
        check("t4_rst_count", 32'(count), 32'd0);
        check("t4_rst_done",  32'(done),  32'd0);
        push = 1'b1; push_addr = 4'h8; push_data = 8'h88;
        tick();
        push = 1'b0;
        check("t4_count", 32'(count), 32'd1);
        n = 0; early = 0;
        while (busy === 1'b1 && n < 60) begin
            if (wrt !== 1'b0) early++;
            tick();
            n++;
        end
        check("t4_busy_fall",   32'(busy),     32'd0);
        check("t4_wrt_early",   32'(early),    32'd0);
        check("t4_no_done",     32'(done_cnt), 32'(dc));
        check("t4_wrt_pre",     32'(wrt),      32'd0);
        tick();
        check("t4_wrt_rise", 32'(wrt),      32'd1);
        check("t4_addr",     32'(addr_out), 32'h8);
        check("t4_data",     32'(data_out), 32'h88);
        wait_done("t4_done");
        wait_idle();
        if (seen.size() >= 1) check("t4_seen", 32'(seen[seen.size()-1]), 32'h888);

        // 5: busy held high while idle with one entry pending
        busy_hold = 1'b1;
        push = 1'b1; push_addr = 4'h9; push_data = 8'h99;
        tick();
        push = 1'b0;
        early = 0;
        repeat (6) begin
            tick();
            if (wrt !== 1'b0) early++;
        end
        check("t5_wrt_held", 32'(early), 32'd0);
        check("t5_count",    32'(count), 32'd1);
        busy_hold = 1'b0;
        #1;
        check("t5_wrt_pre", 32'(wrt), 32'd0);
        tick();
        check("t5_wrt_rise", 32'(wrt), 32'd1);
        wait_done("t5_done");
        wait_idle();

        // 6: fill/drain three times to exercise pointer wrap
        stab_err = 0;
        for (int r = 0; r < 3; r++) begin
            seen.delete();
            for (int k = 0; k < 4; k++) begin
                push = 1'b1; push_addr = 4'(k + 1); push_data = 8'(8'hA0 + r * 4 + k);
                tick();
            end
            push = 1'b0;
            check($sformatf("t6_full_%0d", r), 32'(full), 32'd1);
            for (int k = 0; k < 4; k++) wait_done($sformatf("t6_done_%0d_%0d", r, k));
            wait_idle();
            check($sformatf("t6_writes_%0d", r), 32'(seen.size()), 32'd4);
            for (int k = 0; k < 4 && k < seen.size(); k++) begin
                e = {4'(k + 1), 8'(8'hA0 + r * 4 + k)};
                check($sformatf("t6_seen_%0d_%0d", r, k), 32'(seen[k]), 32'(e));
            end
        end
        check("t6_stable", 32'(stab_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/write_queue.md
# write_queue

Upstream feeder for `write_synch`. It buffers write requests (address + data) from the fast-clock control logic in a small FIFO. It issues them one at a time over the `wrt`/`busy`/`en_n` handshake and holds address and data stable for the whole slow-clock write. `wrt`, `addr_out` and `data_out` go to `write_synch` and the slow device; `busy` and `en_n` come back from `write_synch`.

## Interface
- `AW`, default 4: address width
- `DW`, default 8: data width
- `DEPTH`, default 4: FIFO entries, power of two, at least 2
- `clk` in 1: system (fast) clock; all logic on the rising edge
- `rst` in 1: reset, synchronous, active-high
- `push` in 1: enqueue request this cycle
- `push_addr` in AW: address of the pushed request
- `push_data` in DW: data of the pushed request
- `full` out 1: FIFO holds DEPTH entries
- `empty` out 1: FIFO holds 0 entries
- `count` out $clog2(DEPTH+1): current occupancy
- `wrt` out 1: write request to `write_synch`
- `busy` in 1: from `write_synch`
- `en_n` in 1: from `write_synch`, active-low device enable
- `addr_out` out AW: address presented to the device
- `data_out` out DW: data presented to the device
- `done` out 1: one-cycle pulse when a write has completed

## Operation
- The FIFO is circular with read and write pointers and a count.
  - `push` is accepted only when `full`=0 in that cycle.
  - A push while full is dropped, even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full: count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - **IDLE** (`wrt`=0)
    - Moves to REQ when `empty`=0 and `busy`=0.
    - On that edge it loads the head entry into `addr_out`/`data_out`.
  - **REQ** (`wrt`=1)
    - Waits for `en_n`=0, then moves to HOLD.
  - **HOLD** (`wrt`=1)
    - Waits for `en_n`=1 (end of the enable pulse), then moves to REL.
  - **REL** (`wrt`=0)
    - Waits for `busy`=0.
    - Then pops the head entry, pulses `done`, and returns to IDLE.
- `addr_out`/`data_out` change only on the IDLE→REQ edge. They stay constant through REQ, HOLD and REL.
- `wrt` is a registered output, taken directly from the state (REQ or HOLD).
- `busy` is ignored in REQ. `write_synch` raises it one cycle after `wrt`.

## Timing
- Reset values:
  - `wrt`=0, `done`=0, `addr_out`=0, `data_out`=0
  - `count`=0, `empty`=1, `full`=0
  - FSM in IDLE, pointers 0
- Reset in any state: the next edge gives `wrt`=0 and an empty FIFO, and pending entries are lost.
  - `write_synch` has no reset. It drains back to idle once `wrt`=0.
  - The IDLE guard `busy`=0 prevents a new request until that drain is complete.
- Latency from a push into an empty, idle queue: `wrt` rises 2 cycles after the push edge.
  - Edge 1 writes the entry.
  - Edge 2 takes IDLE→REQ.
- `done` is asserted in the cycle after the REL→IDLE edge. `count` decrements on that same edge.
- Back-to-back writes: the minimum gap between `done` and the next `wrt` rise is 1 cycle, because IDLE re-checks `busy`.
- `full`, `empty` and `count` are registered and reflect state after the last edge.

## Structure
- Package `write_queue_pkg` holds:
  - the state encoding constants: IDLE=2'b00, REQ=2'b01, HOLD=2'b10, REL=2'b11
  - a request struct/typedef {addr, data} sized by AW/DW
- One sub-module, `req_fifo`: parameterised synchronous FIFO with push/pop, full/empty/count and a head-data output.
- The top level holds the FSM and the output registers.

## Test plan
The bench models `write_synch` exactly, with `slc` at a period of 8 `clk` cycles (4 high, 4 low).
1. Reset, then one push (addr 4'h3, data 8'hA5):
   - `wrt` rises 2 cycles later.
   - Exactly one `en_n` low pulse, lasting 4 cycles, with `addr_out`=3 and `data_out`=A5 stable throughout.
   - One `done` pulse, and `count` returns to 0.
2. Push 4 entries (1/11, 2/22, 3/33, 4/44) on consecutive cycles:
   - `full`=1 after the 4th.
   - A 5th push (5/55) is ignored.
   - The device sees exactly 4 writes, in order 11, 22, 33, 44.
3. Push on the same cycle as a pop, with `count`=2: `count` stays 2, and the order of writes is preserved.
4. Assert `rst` for 1 cycle during HOLD:
   - `wrt`=0 on the next edge, FIFO empty, no `done`.
   - A push afterwards is issued only after the model's `busy`=0.
5. Hold `busy`=1 from the model while in IDLE with `count`=1: `wrt` stays 0 until `busy` falls, then rises 1 cycle later.
6. Fill, drain and refill 3 times with DEPTH=4: pointer wrap-around is exercised, and all 12 data values arrive in push order.
